// File: rtl/mux_sel_sequencer.sv
// Drives the operand-mux select through a programmed run of elements, with repeated sweeps and a valid/ready handshake.
// Define MUX_SEQ_STRIDE_EN to add the stride port; without it the select steps by 1.
//
// state | meaning
// IDLE  | waiting for start; latches run parameters
// RUN   | presenting one element per accepted beat
// DONE  | one-cycle completion pulse, then back to IDLE

module mux_sel_sequencer #(
  parameter int SEL_W = 5,
  parameter int LEN_W = 6,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] base,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
`ifdef MUX_SEQ_STRIDE_EN
  input  logic [SEL_W-1:0] stride,
`endif
  input  logic             abort,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  localparam logic [REP_W-1:0] ONE_R = REP_W'(1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n, base_q, base_n, step_q, step_n, step_in;
  logic [LEN_W-1:0] len_q, len_n, elem_cnt, elem_n;
  logic [REP_W-1:0] reps_q, reps_n, rep_cnt, rep_n;
  logic             valid_n, last_n, busy_n, done_n, err_n;

`ifdef MUX_SEQ_STRIDE_EN
  assign step_in = stride;
`else
  assign step_in = SEL_W'(1);
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    base_n  = base_q;
    len_n   = len_q;
    reps_n  = reps_q;
    step_n  = step_q;
    elem_n  = elem_cnt;
    rep_n   = rep_cnt;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (len != '0) begin
            state_n = RUN;
            base_n  = base;
            len_n   = len;
            reps_n  = reps;
            step_n  = step_in;
            sel_n   = base;
            elem_n  = '0;
            rep_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (elem_cnt == len_q - ONE_L) begin
            if (rep_cnt == reps_q) begin
              state_n = DONE;
            end else begin
              sel_n  = base_q;
              elem_n = '0;
              rep_n  = rep_cnt + ONE_R;
            end
          end else begin
            // 5-bit overflow gives the 31 -> 0 wrap for free
            sel_n  = sel + step_q;
            elem_n = elem_cnt + ONE_L;
          end
        end
        if (abort) state_n = IDLE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    valid_n = (state_n == RUN);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
    last_n  = (state_n == RUN) && (elem_n == len_n - ONE_L);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      base_q    <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      step_q    <= '0;
      elem_cnt  <= '0;
      rep_cnt   <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      base_q    <= base_n;
      len_q     <= len_n;
      reps_q    <= reps_n;
      step_q    <= step_n;
      elem_cnt  <= elem_n;
      rep_cnt   <= rep_n;
      out_valid <= valid_n;
      last      <= last_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Sequencer that drives the 5-bit select of the 32-way, 16-bit operand multiplexer in the matrix multiplier. It walks the select through a programmed run of elements, with wrap-around and optional repeated sweeps, and presents each element to the downstream MAC with a valid/ready handshake. It sits between the matrix-multiply control FSM (start/done) and the mux/MAC datapath.

## Interface
Parameters:
- SEL_W, 5, select width; mux depth is 2^SEL_W = 32.
- LEN_W, 6, length field width; must hold the value 32.
- REP_W, 4, repeat field width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE.
- base  in  SEL_W  first select index of each sweep.
- len  in  LEN_W  elements per sweep; legal range 1..32.
- reps  in  REP_W  extra sweeps; total sweeps = reps+1.
- stride  in  SEL_W  select increment; present only with MUX_SEQ_STRIDE_EN.
- abort  in  1  terminates the current run.
- out_ready  in  1  downstream accepts the current element.
- sel  out  SEL_W  registered select to the mux.
- out_valid  out  1  sel (and mux output) is valid.
- last  out  1  current beat is the final element of a sweep.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse when start arrives with len==0.

## Operation
- States: IDLE, RUN, DONE.
- Reset (synchronous, priority over everything): state=IDLE; sel=0, out_valid=0, last=0, busy=0, done=0, err=0.
- IDLE:
  - If start=1 and len!=0, latch base, len, reps (and stride) and go to RUN. sel=base, elem_cnt=0, rep_cnt=0.
  - If start=1 and len==0, pulse err next cycle and stay in IDLE.
  - If start and abort are both high in the same cycle, abort wins: start is ignored.
- RUN:
  - out_valid=1. A beat transfers when out_valid and out_ready are both high; sel, last and counters hold while out_ready=0.
  - On a transfer: sel <= (sel + step) mod 32, with step = latched stride (macro on) or 1. elem_cnt increments.
  - last=1 while elem_cnt==len-1.
  - On a last transfer: if rep_cnt==reps, go to DONE. Otherwise sel <= base, elem_cnt <= 0, rep_cnt increments.
- DONE: out_valid=0, done=1 for exactly one cycle, then IDLE.
- abort in RUN or DONE: next state is IDLE, out_valid=0, no done pulse. A beat accepted in the abort cycle still counts as transferred.
- start is ignored outside IDLE. Input changes after the start cycle have no effect.
- len=32 with step 1 visits all 32 indices exactly once per sweep. Index wrap from 31 to 0 is natural 5-bit overflow.

## Timing
- sel, out_valid, last, busy, done and err are all registered.
- The mux is combinational, so data is valid in the same cycle as sel.
- start sampled at edge 0 → first out_valid and busy=1 at cycle 1.
- With out_ready tied high, one element transfers per cycle. The final beat is at cycle len*(reps+1), done=1 at cycle len*(reps+1)+1, and busy=0 the cycle after.
- A new start can be accepted in the first IDLE cycle after DONE, so the minimum gap between runs is 2 cycles.
- err asserts 1 cycle after the offending start.

## Configuration
- MUX_SEQ_STRIDE_EN defined:
  - The stride port exists and is latched at start.
  - step = stride mod 32; stride=0 repeats base for every element.
- MUX_SEQ_STRIDE_EN undefined:
  - No stride port; step is fixed at 1.
  - All other behaviour is identical.

## Test plan
- Basic run: base=0, len=4, reps=0, ready=1 → sel 0,1,2,3 on cycles 1–4, last on the sel=3 beat, done at cycle 5.
- Wrap and repeat: base=30, len=4, reps=1 → sel 30,31,0,1,30,31,0,1, last on both sel=1 beats, exactly one done pulse.
- Backpressure: base=5, len=3, out_ready toggled 1,0,0,1,1 → sel 5 transfers, sel 6 held for 2 cycles, then 6,7 transfer; no element skipped or duplicated.
- Error and abort:
  - start with len=0 → err pulse, busy stays 0.
  - abort mid-run with len=8 → out_valid=0 the next cycle and no done pulse.
  - start held high during RUN is ignored.
- Stride (macro on): base=1, stride=8, len=5 → sel 1,9,17,25,1.
- Full sweep and reset: len=32, base=0 → all indices 0..31 in order; reset asserted during RUN → all outputs 0 the next cycle.
